// File: rtl/uart_tx_core_param.sv
// Parametrised UART transmitter: control FSM, serializer, parity and line driver in one block.
// Optional line-break generation is compiled in with `define UART_TX_BREAK_EN.
module uart_tx_core_param #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STP_2,
`ifdef UART_TX_BREAK_EN
  input  logic                  Break_Req,
`endif
  output logic                  Ready,
  output logic                  TX_OUT,
  output logic                  Busy,
  output logic [2:0]            dbg_state_o
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;
`ifdef UART_TX_BREAK_EN
  localparam logic [2:0] BREAK  = 3'd5;
`endif

  logic [2:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  stop_cnt_q, stop_cnt_d;
  logic                  par_q, par_d;
  logic                  par_en_q, par_en_d;
  logic                  stp2_q, stp2_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  brk_w;
  logic                  stop_last;
  logic                  accept;

`ifdef UART_TX_BREAK_EN
  assign brk_w = Break_Req;
`else
  assign brk_w = 1'b0;
`endif

  // Handshake: a payload is taken on any rising CLK edge where Ready and Data_Valid
  // are both 1; Ready does not depend on Data_Valid, and the requester holds
  // Data_Valid (and P_DATA/config) stable until that edge.
  assign stop_last = !stp2_q || stop_cnt_q;
  assign Ready     = ((state_q == IDLE) && !brk_w) || ((state_q == STOP) && stop_last);
  assign accept    = Ready && Data_Valid;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    stop_cnt_d = stop_cnt_q;
    par_d      = par_q;
    par_en_d   = par_en_q;
    stp2_d     = stp2_q;

    case (state_q)
      IDLE: begin
`ifdef UART_TX_BREAK_EN
        if (brk_w) state_d = BREAK;
`endif
      end
      START: begin
        state_d = DATA;
        cnt_d   = '0;
      end
      DATA: begin
        shift_d = shift_q >> 1;
        if (cnt_q == LAST_BIT) begin
          state_d    = par_en_q ? PARITY : STOP;
          stop_cnt_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PARITY: begin
        state_d    = STOP;
        stop_cnt_d = 1'b0;
      end
      STOP: begin
        if (stop_last) state_d = IDLE;
        else           stop_cnt_d = 1'b1;
      end
`ifdef UART_TX_BREAK_EN
      BREAK: begin
        // Leaving a break forces a single stop cycle, which is then the final one.
        if (!brk_w) begin
          state_d    = STOP;
          stop_cnt_d = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    if (accept) begin
      state_d  = START;
      shift_d  = P_DATA;
      par_d    = (^P_DATA) ^ PAR_TYP;
      par_en_d = PAR_EN;
      stp2_d   = STP_2;
    end
  end

  // Line level and Busy are derived from the next state so they change with the state register.
  always_comb begin
    busy_d = (state_d != IDLE);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_q;
`ifdef UART_TX_BREAK_EN
      BREAK:   tx_d = 1'b0;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      stop_cnt_q <= 1'b0;
      par_q      <= 1'b0;
      par_en_q   <= 1'b0;
      stp2_q     <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      stop_cnt_q <= stop_cnt_d;
      par_q      <= par_d;
      par_en_q   <= par_en_d;
      stp2_q     <= stp2_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

  assign TX_OUT      = tx_q;
  assign Busy        = busy_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_tx_core_param.sv
// Randomised self-checking bench for uart_tx_core_param: a per-cycle line-level
// reference (expected {Busy,TX_OUT} queue) built from frame rules.
module tb_uart_tx_core_param;
  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST;
  logic [W-1:0] P_DATA;
  logic         Data_Valid;
  logic         PAR_EN;
  logic         PAR_TYP;
  logic         STP_2;
`ifdef UART_TX_BREAK_EN
  logic         Break_Req;
`endif
  logic         Ready;
  logic         TX_OUT;
  logic         Busy;
  logic [2:0]   dbg_state;

  logic [1:0]   exp_q[$];
  int           total = 0;
  int           bad = 0;
  bit           mon_en = 1'b0;

  uart_tx_core_param #(.DATA_WIDTH(W)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .STP_2      (STP_2),
`ifdef UART_TX_BREAK_EN
    .Break_Req  (Break_Req),
`endif
    .Ready      (Ready),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Expected line content of one frame, one entry {busy,tx} per bit time.
  task automatic push_frame(input logic [W-1:0] d, input bit pe, input bit pt, input bit s2);
    exp_q.push_back(2'b10);
    for (int i = 0; i < W; i++) exp_q.push_back({1'b1, d[i]});
    if (pe) exp_q.push_back({1'b1, 1'(($countones(d) % 2) != 0) ^ pt});
    exp_q.push_back(2'b11);
    if (s2) exp_q.push_back(2'b11);
  endtask

  // scoreboard: line is idle when nothing is expected; Ready exactly when nothing remains
  always @(negedge CLK) begin
    logic [1:0] e;
    if (mon_en) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 2'b01;
      check_eq("busy", {31'd0, Busy}, {31'd0, e[1]});
      check_eq("tx", {31'd0, TX_OUT}, {31'd0, e[0]});
      check_eq("ready", {31'd0, Ready}, (exp_q.size() == 0) ? 32'd1 : 32'd0);
    end
  end

  // driver: hold request, scramble payload/config while not ready, present real values just in time
  task automatic send(input logic [W-1:0] d, input bit pe, input bit pt, input bit s2);
    int guard;
    guard = 0;
    Data_Valid = 1'b1;
    while (exp_q.size() != 0 && guard < 200) begin
      P_DATA  = W'($urandom);
      PAR_EN  = 1'($urandom);
      PAR_TYP = 1'($urandom);
      STP_2   = 1'($urandom);
      @(negedge CLK); #1;
      guard++;
    end
    if (guard >= 200) check_eq("send_timeout", 32'd0, 32'd1);
    P_DATA  = d;
    PAR_EN  = pe;
    PAR_TYP = pt;
    STP_2   = s2;
    @(posedge CLK);
    push_frame(d, pe, pt, s2);
    #1;
    Data_Valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(negedge CLK); #1;
      guard++;
    end
    if (guard >= 100) check_eq("idle_timeout", 32'd0, 32'd1);
    repeat (2) begin
      @(negedge CLK); #1;
    end
  endtask

  initial begin
    RST = 1'b1; Data_Valid = 1'b0; P_DATA = '0;
    PAR_EN = 1'b0; PAR_TYP = 1'b0; STP_2 = 1'b0;
`ifdef UART_TX_BREAK_EN
    Break_Req = 1'b0;
`endif
    #12;
    check_eq("rst_tx", {31'd0, TX_OUT}, 32'd1);
    check_eq("rst_busy", {31'd0, Busy}, 32'd0);
    check_eq("rst_ready", {31'd0, Ready}, 32'd1);
    @(negedge CLK); RST = 1'b0; #1;
    mon_en = 1'b1;
    repeat (2) begin
      @(negedge CLK); #1;
    end

    send(8'hA5, 1'b1, 1'b0, 1'b0); wait_idle();
    send(8'hA5, 1'b1, 1'b1, 1'b1); wait_idle();
    send(8'h3C, 1'b0, 1'b0, 1'b0);
    send(8'hFF, 1'b0, 1'b0, 1'b0); wait_idle();
    send(8'h55, 1'b1, 1'b0, 1'b1);
    send(8'h55, 1'b0, 1'b1, 1'b0);
    send(8'hC3, 1'b1, 1'b1, 1'b0); wait_idle();

    // asynchronous reset during data bit 4 (a 0 bit of 0x0F)
    send(8'h0F, 1'b0, 1'b0, 1'b0);
    repeat (5) @(posedge CLK);
    #2;
    mon_en = 1'b0;
    RST = 1'b1;
    #1;
    check_eq("async_rst_tx", {31'd0, TX_OUT}, 32'd1);
    check_eq("async_rst_busy", {31'd0, Busy}, 32'd0);
    check_eq("async_rst_ready", {31'd0, Ready}, 32'd1);
    exp_q.delete();
    @(negedge CLK);
    @(negedge CLK); RST = 1'b0; #1;
    mon_en = 1'b1;
    send(8'h81, 1'b1, 1'b0, 1'b0); wait_idle();

    for (int n = 0; n < 40; n++) begin
      send(W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 2) == 0) wait_idle();
      repeat ($urandom_range(0, 3)) begin
        @(negedge CLK); #1;
      end
    end
    wait_idle();

`ifdef UART_TX_BREAK_EN
    Break_Req  = 1'b1;
    Data_Valid = 1'b1;
    P_DATA     = 8'h5A;
    @(posedge CLK);
    repeat (15) exp_q.push_back(2'b10);
    exp_q.push_back(2'b11);
    repeat (14) @(posedge CLK);
    #1;
    Break_Req = 1'b0;
    send(8'h5A, 1'b1, 1'b0, 1'b0);
    wait_idle();
`endif

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
